ttt_turn_controller: RTL and testbench

Sequencing FSM for the 3x3 tic-tac-toe game. Owns the board register, accepts player moves, enforces turn order and a per-turn time limit, and auto-places a piece on timeout. After each placement it pulses `en_check` to the external combinational winner checker, then ends the game or hands the turn to the other player.

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/ttt_turn_controller_if.sv | 33 +++
 rtl/turn_timer.sv | 27 ++
 rtl/ttt_turn_controller.sv | 118 +++++++++++
 tb/tb_ttt_turn_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell/board encoding, player constants and controller states.
// Used by the turn controller, the winner checker and the display block.
package ttt_pkg;

  typedef logic [1:0] cell_t;
  typedef cell_t [3:1][3:1] board_t;

  localparam cell_t EMPTY = 2'd0;
  localparam cell_t P1    = 2'd1;
  localparam cell_t P2    = 2'd2;
  localparam cell_t DRAW  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    AUTO,
    CHECK,
    DONE
  } ctrl_state_t;

  // Off-board coordinates (row or col 0) read as occupied so they are refused like a taken cell.
  function automatic cell_t cell_at(board_t b, logic [1:0] r, logic [1:0] c);
    cell_t v;
    v = DRAW;
    for (int i = 1; i <= 3; i++)
      for (int j = 1; j <= 3; j++)
        if (r == 2'(i) && c == 2'(j)) v = b[i][j];
    return v;
  endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Player/checker/display signal bundle for the turn controller.
// master = surrounding game logic, slave = ttt_turn_controller.
interface ttt_turn_controller_if
  import ttt_pkg::*;
#(parameter int CNT_W = 29);

  logic             start;
  logic             move_valid;
  logic [1:0]       move_row;
  logic [1:0]       move_col;
  cell_t            winner;
  board_t           board;
  logic             en_check;
  cell_t            current_player;
  logic             game_over;
  cell_t            result;
  logic             move_reject;
  logic             timeout;
  logic [CNT_W-1:0] time_left;

  modport master (
    output start, move_valid, move_row, move_col, winner,
    input  board, en_check, current_player, game_over, result,
           move_reject, timeout, time_left
  );

  modport slave (
    input  start, move_valid, move_row, move_col, winner,
    output board, en_check, current_player, game_over, result,
           move_reject, timeout, time_left
  );

endinterface

// File: rtl/turn_timer.sv
// Per-turn down-counter: load restarts at TURN_CYCLES-1, run decrements and saturates at 0.
module turn_timer #(
  parameter int TURN_CYCLES = 500_000_000,
  parameter int CNT_W       = $clog2(TURN_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TURN_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= RELOAD;
    else if (load)
      count <= RELOAD;
    else if (run && count != '0)
      count <= count - CNT_W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the board, enforces turn order and the turn timer.
// IDLE: wait start | WAIT_MOVE: player to move | AUTO: timeout scan | CHECK: winner sample | DONE: game over
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int TURN_CYCLES = 500_000_000,
  parameter int CNT_W       = $clog2(TURN_CYCLES)
) (
  input logic                  clk,
  input logic                  rst,
  ttt_turn_controller_if.slave bus
);

  ctrl_state_t      state;
  board_t           board_q;
  cell_t            player_q;
  cell_t            result_q;
  logic             game_over_q;
  logic             reject_q;
  logic             timeout_q;
  logic [1:0]       scan_row;
  logic [1:0]       scan_col;
  logic             timer_load;
  logic             timer_run;
  logic             expired;
  logic [CNT_W-1:0] time_left;
  logic             move_ok;

  assign timer_load = bus.start || (state == CHECK && bus.winner == EMPTY);
  assign timer_run  = (state == WAIT_MOVE);
  assign move_ok    = (cell_at(board_q, bus.move_row, bus.move_col) == EMPTY);

  turn_timer #(.TURN_CYCLES(TURN_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .run     (timer_run),
    .count   (time_left),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      board_q     <= '0;
      player_q    <= P1;
      result_q    <= EMPTY;
      game_over_q <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
      scan_row    <= 2'd1;
      scan_col    <= 2'd1;
    end else begin
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      if (bus.start) begin
        state       <= WAIT_MOVE;
        board_q     <= '0;
        player_q    <= P1;
        result_q    <= EMPTY;
        game_over_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: ;
          WAIT_MOVE: begin
            if (bus.move_valid && move_ok) begin
              board_q[bus.move_row][bus.move_col] <= player_q;
              state <= CHECK;
            end else begin
              if (bus.move_valid) reject_q <= 1'b1;
              if (expired) begin
                timeout_q <= 1'b1;
                scan_row  <= 2'd1;
                scan_col  <= 2'd1;
                state     <= AUTO;
              end
            end
          end
          AUTO: begin
            // Row-major scan; a full board (last cell reached) still goes on to CHECK.
            if (cell_at(board_q, scan_row, scan_col) == EMPTY) begin
              board_q[scan_row][scan_col] <= player_q;
              state <= CHECK;
            end else if (scan_row == 2'd3 && scan_col == 2'd3) begin
              state <= CHECK;
            end else if (scan_col == 2'd3) begin
              scan_col <= 2'd1;
              scan_row <= scan_row + 2'd1;
            end else begin
              scan_col <= scan_col + 2'd1;
            end
          end
          CHECK: begin
            if (bus.winner != EMPTY) begin
              result_q    <= bus.winner;
              game_over_q <= 1'b1;
              state       <= DONE;
            end else begin
              player_q <= (player_q == P1) ? P2 : P1;
              state    <= WAIT_MOVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.board          = board_q;
  assign bus.en_check       = (state == CHECK);
  assign bus.current_player = player_q;
  assign bus.game_over      = game_over_q;
  assign bus.result         = result_q;
  assign bus.move_reject    = reject_q;
  assign bus.timeout        = timeout_q;
  assign bus.time_left      = time_left;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Self-checking bench for ttt_turn_controller with an 8-cycle turn; board scoreboard popped on en_check.
module tb_ttt_turn_controller;
  import ttt_pkg::*;

  localparam int TC = 8;
  localparam int CW = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  board_t mb;
  cell_t  exp_player;
  board_t sb_q[$];

  ttt_turn_controller_if #(.CNT_W(CW)) bus ();

  ttt_turn_controller #(.TURN_CYCLES(TC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard side: every CHECK cycle must match the next expected board.
  always @(negedge clk) begin
    if (!rst && bus.en_check === 1'b1) begin
      if (sb_q.size() == 0) check_val("unexpected_check", 32'(bus.en_check), 0);
      else check_val("sb_board", 32'(bus.board), 32'(sb_q.pop_front()));
    end
  end

  task automatic check_fresh(input string tag);
    check_val({tag, "_board"},  32'(bus.board), 0);
    check_val({tag, "_player"}, 32'(bus.current_player), 1);
    check_val({tag, "_encheck"}, 32'(bus.en_check), 0);
    check_val({tag, "_over"},   32'(bus.game_over), 0);
    check_val({tag, "_result"}, 32'(bus.result), 0);
    check_val({tag, "_reject"}, 32'(bus.move_reject), 0);
    check_val({tag, "_timeout"}, 32'(bus.timeout), 0);
    check_val({tag, "_tleft"},  32'(bus.time_left), TC - 1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    mb = '0;
    exp_player = P1;
    check_fresh("start");
  endtask

  task automatic play(input logic [1:0] r, input logic [1:0] c, input cell_t win);
    mb[r][c] = exp_player;
    sb_q.push_back(mb);
    bus.winner     = win;
    bus.move_valid = 1'b1;
    bus.move_row   = r;
    bus.move_col   = c;
    tick();
    bus.move_valid = 1'b0;
    check_val("accept_encheck", 32'(bus.en_check), 1);
    check_val("accept_no_timeout", 32'(bus.timeout), 0);
    tick();
    if (win != EMPTY) begin
      check_val("end_over", 32'(bus.game_over), 1);
      check_val("end_result", 32'(bus.result), 32'(win));
    end else begin
      exp_player = (exp_player == P1) ? P2 : P1;
      check_val("turn_player", 32'(bus.current_player), 32'(exp_player));
      check_val("turn_tleft", 32'(bus.time_left), TC - 1);
    end
    bus.winner = EMPTY;
  endtask

  task automatic reject_move(input logic [1:0] r, input logic [1:0] c, input int tl_exp);
    bus.move_valid = 1'b1;
    bus.move_row   = r;
    bus.move_col   = c;
    tick();
    bus.move_valid = 1'b0;
    check_val("rej_pulse", 32'(bus.move_reject), 1);
    check_val("rej_board", 32'(bus.board), 32'(mb));
    check_val("rej_player", 32'(bus.current_player), 32'(exp_player));
    check_val("rej_tleft", 32'(bus.time_left), 32'(tl_exp));
    tick();
    check_val("rej_once", 32'(bus.move_reject), 0);
  endtask

  // Called on the cycle timeout is visible; k = index of first empty cell.
  task automatic auto_finish(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check_val("auto_scan_encheck", 32'(bus.en_check), 0);
    end
    tick();
    check_val("auto_encheck", 32'(bus.en_check), 1);
    tick();
    exp_player = (exp_player == P1) ? P2 : P1;
    check_val("auto_player", 32'(bus.current_player), 32'(exp_player));
    check_val("auto_tleft", 32'(bus.time_left), TC - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_row = 2'd0;
    bus.move_col = 2'd0;
    bus.winner = EMPTY;
    mb = '0;
    exp_player = P1;
    repeat (2) tick();
    check_fresh("reset");
    rst = 1'b0;
    tick();

    // Game 1: P1 wins the top row, with rejected requests along the way.
    do_start();
    play(2'd1, 2'd1, EMPTY);
    reject_move(2'd1, 2'd1, TC - 2);
    reject_move(2'd0, 2'd2, TC - 4);
    play(2'd2, 2'd1, EMPTY);
    play(2'd1, 2'd2, EMPTY);
    play(2'd2, 2'd2, EMPTY);
    play(2'd1, 2'd3, P1);
    bus.move_valid = 1'b1;
    bus.move_row = 2'd3;
    bus.move_col = 2'd3;
    tick();
    bus.move_valid = 1'b0;
    tick();
    check_val("done_board", 32'(bus.board), 32'(mb));
    check_val("done_no_reject", 32'(bus.move_reject), 0);
    check_val("done_over", 32'(bus.game_over), 1);

    // Timeout with (1,1),(1,2) taken: auto-place at (1,3).
    do_start();
    play(2'd1, 2'd1, EMPTY);
    play(2'd1, 2'd2, EMPTY);
    repeat (TC - 1) tick();
    check_val("tl_zero", 32'(bus.time_left), 0);
    check_val("tl_zero_no_timeout", 32'(bus.timeout), 0);
    tick();
    check_val("timeout_pulse", 32'(bus.timeout), 1);
    mb[1][3] = exp_player;
    sb_q.push_back(mb);
    auto_finish(2);

    // Legal move exactly when the timer is at 0.
    repeat (TC - 1) tick();
    check_val("race_tl_zero", 32'(bus.time_left), 0);
    play(2'd2, 2'd2, EMPTY);

    // Illegal move when the timer is at 0: reject and timeout together, auto lands at (2,1).
    repeat (TC - 1) tick();
    bus.move_valid = 1'b1;
    bus.move_row = 2'd2;
    bus.move_col = 2'd2;
    tick();
    bus.move_valid = 1'b0;
    check_val("race_rej", 32'(bus.move_reject), 1);
    check_val("race_timeout", 32'(bus.timeout), 1);
    mb[2][1] = exp_player;
    sb_q.push_back(mb);
    auto_finish(3);

    // Reset in the middle of an AUTO scan.
    repeat (TC) tick();
    check_val("pre_rst_timeout", 32'(bus.timeout), 1);
    tick();
    rst = 1'b1;
    #1;
    check_fresh("rst_auto");
    tick();
    rst = 1'b0;

    // Draw game, then start clears it.
    do_start();
    play(2'd1, 2'd1, EMPTY);
    play(2'd1, 2'd2, EMPTY);
    play(2'd1, 2'd3, EMPTY);
    play(2'd2, 2'd2, EMPTY);
    play(2'd2, 2'd1, EMPTY);
    play(2'd2, 2'd3, EMPTY);
    play(2'd3, 2'd2, EMPTY);
    play(2'd3, 2'd1, EMPTY);
    play(2'd3, 2'd3, DRAW);
    do_start();

    // Start mid-game while P2 is thinking.
    play(2'd2, 2'd2, EMPTY);
    repeat (3) tick();
    check_val("mid_tleft", 32'(bus.time_left), TC - 4);
    do_start();

    check_val("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
